// File: rtl/ahb_slave_arbiter_param.sv
// Per-slave AHB arbiter: fixed-priority or round-robin selection among MASTER_NUM masters,
// grant held for a whole transaction with optional beat limit forcing re-arbitration.
module ahb_slave_arbiter_param #(
  parameter int MASTER_NUM = 4,
  parameter int ARB_MODE   = 1,
  parameter int MAX_BEATS  = 16,
  localparam int IDX_W     = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [MASTER_NUM-1:0] hlast,
  input  logic                  hwait,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [IDX_W-1:0]      hmaster,
  output logic [7:0]            hbeat_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [7:0]            beat_q, beat_d;

  logic                  owner_req;
  logic                  owner_last;
  logic                  others_req;
  logic                  rel_end;
  logic                  rel_abandon;
  logic                  rel_force;
  logic                  release_now;
  logic                  load;
  logic [MASTER_NUM-1:0] cand;
  logic [IDX_W:0]        pick;
  logic [IDX_W-1:0]      win;
  logic [IDX_W-1:0]      search_base;

  // Returns {found, index}; the scan runs downward so the lowest search offset wins.
  function automatic logic [IDX_W:0] pick_winner(input logic [MASTER_NUM-1:0] req,
                                                  input logic [IDX_W-1:0]      base);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = MASTER_NUM - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % MASTER_NUM;
      if (req[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    return (int'(w) == MASTER_NUM - 1) ? '0 : w + 1'b1;
  endfunction

  // Release conditions evaluated against the current owner only
  always_comb begin
    owner_req   = hreq[owner_q];
    owner_last  = hlast[owner_q];
    others_req  = |(hreq & ~grant_q);
    rel_end     = owner_req & owner_last;
    rel_abandon = ~owner_req;
    rel_force   = (MAX_BEATS != 0) && (int'(beat_q) == MAX_BEATS - 1) && others_req;
    release_now = (state_q == ST_OWNED) && !hwait && (rel_end || rel_abandon || rel_force);
  end

  // State and grant registers
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state: hold, count, release and same-cycle re-arbitration
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    beat_d      = beat_q;
    load        = 1'b0;
    cand        = hreq;
    search_base = (ARB_MODE == 1) ? rr_q : '0;

    case (state_q)
      ST_IDLE: begin
        if (|hreq) load = 1'b1;
      end
      ST_OWNED: begin
        if (!hwait) begin
          if (release_now) begin
            if (rel_abandon) cand = hreq & ~grant_q;
            if (|cand) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
              owner_d = '0;
              beat_d  = '0;
            end
          end else begin
            beat_d = sat_inc(beat_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pick = pick_winner(cand, search_base);
    win  = pick[IDX_W-1:0];

    if (load && pick[IDX_W]) begin
      state_d = ST_OWNED;
      grant_d = MASTER_NUM'(1) << win;
      owner_d = win;
      beat_d  = '0;
      if (ARB_MODE == 1) rr_d = next_ptr(win);
    end
  end

  // Outputs straight from registers
  always_comb begin
    hgrant    = grant_q;
    hsel      = |grant_q;
    hmaster   = (MASTER_NUM == 1) ? '0 : owner_q;
    hbeat_cnt = beat_q;
  end

endmodule

// File: tb/tb_ahb_slave_arbiter_param.sv
// Bench for ahb_slave_arbiter_param: a round-robin/beat-limited instance and a fixed-priority
// unlimited instance share stimulus and are compared each cycle against a transaction-level model.
module tb_ahb_slave_arbiter_param;

  logic       hclk;
  logic       hreset_n;
  logic [3:0] hreq;
  logic [3:0] hlast;
  logic       hwait;

  logic [3:0] g_rr, g_fp;
  logic       s_rr, s_fp;
  logic [1:0] m_rr, m_fp;
  logic [7:0] b_rr, b_fp;

  int n_checks = 0;
  int n_fail   = 0;

  // model state, index 0 = round-robin MAX_BEATS=4, index 1 = fixed priority unlimited
  int m_owner[2];
  int m_beats[2];
  int m_ptr[2];
  int m_mode[2]  = '{1, 0};
  int m_limit[2] = '{4, 0};

  ahb_slave_arbiter_param #(.MASTER_NUM(4), .ARB_MODE(1), .MAX_BEATS(4)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast), .hwait(hwait),
    .hgrant(g_rr), .hsel(s_rr), .hmaster(m_rr), .hbeat_cnt(b_rr)
  );

  ahb_slave_arbiter_param #(.MASTER_NUM(4), .ARB_MODE(0), .MAX_BEATS(0)) u_fp (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast), .hwait(hwait),
    .hgrant(g_fp), .hsel(s_fp), .hmaster(m_fp), .hbeat_cnt(b_fp)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int mode, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (mode == 1) ? (ptr + k) % 4 : k;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic grant_to(input int n, input logic [3:0] req);
    int w;
    w = pick(req, m_mode[n], m_ptr[n]);
    m_owner[n] = w;
    m_beats[n] = 0;
    if (w >= 0 && m_mode[n] == 1) m_ptr[n] = (w + 1) % 4;
  endtask

  task automatic model_step();
    for (int n = 0; n < 2; n++) begin
      int  o;
      bit  rel;
      o = m_owner[n];
      if (!hreset_n) begin
        m_owner[n] = -1;
        m_beats[n] = 0;
        m_ptr[n]   = 0;
      end else if (o < 0) begin
        if (hreq != 0) grant_to(n, hreq);
      end else if (!hwait) begin
        rel = (hreq[o] && hlast[o]) || !hreq[o] ||
              (m_limit[n] != 0 && m_beats[n] == m_limit[n] - 1 && (hreq & ~(4'b1 << o)) != 0);
        if (rel) begin
          grant_to(n, hreq);
        end else if (m_beats[n] < 255) begin
          m_beats[n]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int n = 0; n < 2; n++) begin
      logic [3:0] eg;
      logic [3:0] og;
      logic       os;
      logic [1:0] om;
      logic [7:0] ob;
      eg = (m_owner[n] < 0) ? 4'b0 : (4'b1 << m_owner[n]);
      og = (n == 0) ? g_rr : g_fp;
      os = (n == 0) ? s_rr : s_fp;
      om = (n == 0) ? m_rr : m_fp;
      ob = (n == 0) ? b_rr : b_fp;
      check($sformatf("grant%0d", n), og, eg);
      check($sformatf("hsel%0d", n), os, eg != 0);
      check($sformatf("hmaster%0d", n), om, (m_owner[n] < 0) ? 0 : m_owner[n]);
      check($sformatf("beats%0d", n), ob, m_beats[n]);
    end
  endtask

  task automatic cycle();
    @(posedge hclk);
    model_step();
    @(negedge hclk);
    compare_all();
  endtask

  initial begin
    m_owner  = '{-1, -1};
    m_beats  = '{0, 0};
    m_ptr    = '{0, 0};
    hreq     = 4'b1111;
    hlast    = 4'b0000;
    hwait    = 1'b0;
    hreset_n = 1'b0;

    // reset held with all masters requesting
    cycle();
    cycle();
    check("t1_rst_grant", g_rr, 0);
    check("t1_rst_hsel", s_rr, 0);
    check("t1_rst_hmaster", m_rr, 0);
    hreset_n = 1'b1;
    cycle();
    check("t1_first_rr", g_rr, 4'b0001);
    check("t1_first_fp", g_fp, 4'b0001);

    // single-beat transactions: round-robin rotates, fixed priority sticks to master 0
    hlast = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check($sformatf("t3_rr_%0d", k), g_rr, 4'b1 << (k % 4));
      check($sformatf("t3_fp_%0d", k), g_fp, 4'b0001);
    end

    // master 1 owns three beats, then releases back-to-back
    hreset_n = 1'b0; hlast = 4'b0000; hreq = 4'b1010;
    cycle();
    hreset_n = 1'b1;
    cycle();
    check("t2_own_fp", g_fp, 4'b0010);
    cycle();
    cycle();
    check("t2_beats_fp", b_fp, 2);
    hlast = 4'b0010;
    cycle();
    check("t2_next_rr", g_rr, 4'b1000);
    check("t2_next_fp", g_fp, 4'b0010);
    hreq = 4'b1000; hlast = 4'b0000;
    cycle();
    check("t2_abandon_fp", g_fp, 4'b1000);

    // owner 2 on its last beat, slave stalls for five cycles
    hreset_n = 1'b0; hreq = 4'b0100;
    cycle();
    hreset_n = 1'b1;
    cycle();
    hlast = 4'b0100; hwait = 1'b1; hreq = 4'b0101;
    repeat (5) begin
      cycle();
      check("t4_hold", g_rr, 4'b0100);
      check("t4_beat", b_rr, 0);
    end
    hwait = 1'b0;
    cycle();
    check("t4_rel_rr", g_rr, 4'b0001);
    check("t4_rel_fp", g_fp, 4'b0001);

    // beat limit forces master 0 off only in the limited instance
    hreset_n = 1'b0; hlast = 4'b0000; hreq = 4'b0001;
    cycle();
    hreset_n = 1'b1;
    cycle();
    hreq = 4'b1001;
    repeat (3) cycle();
    check("t5_keep_rr", g_rr, 4'b0001);
    cycle();
    check("t5_force_rr", g_rr, 4'b1000);
    check("t5_keep_fp", g_fp, 4'b0001);
    check("t5_cnt_fp", b_fp, 4);

    // randomized traffic with occasional mid-burst resets
    for (int i = 0; i < 3000; i++) begin
      hreset_n = ($urandom_range(0, 99) != 0);
      hreq     = 4'($urandom_range(0, 15));
      hlast    = 4'($urandom & $urandom);
      hwait    = ($urandom_range(0, 3) == 0);
      if (i % 500 < 60) hlast = 4'b0000;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
